// File: rtl/dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dual_issue_scheduler
// Description : Issue controller between decode and the even/odd execution
//               pipes. Holds one decoded instruction pair (slot A first in
//               program order, slot B second). A per-register latency
//               scoreboard tracks outstanding results. Each instruction is
//               issued to its pipe once its sources are ready. A pair that
//               cannot issue together is split, keeping program order. A
//               taken branch flushes the buffer.
//
// Ports       : clk, reset           clock, async active-high reset
//               i_in_valid/o_in_ready decode pair handshake
//               i_{a,b}_*            slot A / slot B instruction fields
//               i_branch_taken       flush request from the odd pipe
//               o_issue_{even,odd}*  registered one-cycle issue strobes
//                                    and the issued rt / reg_write
//               o_first_odd          issued odd instr precedes the even one
//               o_stall_count        saturating count of stalled cycles
//
// Revision    : 1.0  initial release
// ============================================================================
module dual_issue_scheduler #(
    parameter int NUM_REGS = 128,
    parameter int LAT_W    = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic                        i_a_pipe,
    input  logic                        i_b_pipe,
    input  logic [$clog2(NUM_REGS)-1:0] i_a_rt_addr,
    input  logic [$clog2(NUM_REGS)-1:0] i_b_rt_addr,
    input  logic                        i_a_reg_write,
    input  logic                        i_b_reg_write,
    input  logic [LAT_W-1:0]            i_a_lat,
    input  logic [LAT_W-1:0]            i_b_lat,
    input  logic [$clog2(NUM_REGS)-1:0] i_a_ra,
    input  logic [$clog2(NUM_REGS)-1:0] i_a_rb,
    input  logic [$clog2(NUM_REGS)-1:0] i_a_rc,
    input  logic [$clog2(NUM_REGS)-1:0] i_b_ra,
    input  logic [$clog2(NUM_REGS)-1:0] i_b_rb,
    input  logic [$clog2(NUM_REGS)-1:0] i_b_rc,
    input  logic [2:0]                  i_a_src_used,
    input  logic [2:0]                  i_b_src_used,
    input  logic                        i_branch_taken,
    output logic                        o_issue_even,
    output logic                        o_issue_odd,
    output logic [$clog2(NUM_REGS)-1:0] o_issue_even_rt_addr,
    output logic [$clog2(NUM_REGS)-1:0] o_issue_odd_rt_addr,
    output logic                        o_issue_even_reg_write,
    output logic                        o_issue_odd_reg_write,
    output logic                        o_first_odd,
    output logic [15:0]                 o_stall_count
);

    localparam int c_ADDR_W = $clog2(NUM_REGS);

    // Buffer occupancy
    localparam logic [1:0] c_S_IDLE   = 2'd0;  // empty
    localparam logic [1:0] c_S_PAIR   = 2'd1;  // A and B held
    localparam logic [1:0] c_S_SINGLE = 2'd2;  // only B held

    // ------------------------------------------------------------------------
    // State and held instruction slots
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;

    logic                r_a_pipe;
    logic [c_ADDR_W-1:0] r_a_rt;
    logic                r_a_wr;
    logic [LAT_W-1:0]    r_a_lat;
    logic [c_ADDR_W-1:0] r_a_ra;
    logic [c_ADDR_W-1:0] r_a_rb;
    logic [c_ADDR_W-1:0] r_a_rc;
    logic [2:0]          r_a_used;

    logic                r_b_pipe;
    logic [c_ADDR_W-1:0] r_b_rt;
    logic                r_b_wr;
    logic [LAT_W-1:0]    r_b_lat;
    logic [c_ADDR_W-1:0] r_b_ra;
    logic [c_ADDR_W-1:0] r_b_rb;
    logic [c_ADDR_W-1:0] r_b_rc;
    logic [2:0]          r_b_used;

    // Scoreboard: cycles until each register's value is forwardable
    logic [LAT_W-1:0]    r_cnt     [NUM_REGS];
    logic [LAT_W-1:0]    w_cnt_nxt [NUM_REGS];

    // Registered outputs
    logic                r_issue_even;
    logic                r_issue_odd;
    logic [c_ADDR_W-1:0] r_issue_even_rt;
    logic [c_ADDR_W-1:0] r_issue_odd_rt;
    logic                r_issue_even_wr;
    logic                r_issue_odd_wr;
    logic                r_first_odd;
    logic [15:0]         r_stall_count;

    // Combinational decision signals
    logic                w_a_src_ok;
    logic                w_b_src_ok;
    logic                w_b_raw_on_a;
    logic                w_b_waw_on_a;
    logic                w_a_issue;
    logic                w_b_issue;
    logic                w_drain;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_stall;
    logic [LAT_W-1:0]    w_a_lat_m1;
    logic [LAT_W-1:0]    w_b_lat_m1;

    logic                w_even_issue;
    logic                w_odd_issue;
    logic [c_ADDR_W-1:0] w_even_rt;
    logic [c_ADDR_W-1:0] w_odd_rt;
    logic                w_even_wr;
    logic                w_odd_wr;

    // ------------------------------------------------------------------------
    // Hazard evaluation
    // ------------------------------------------------------------------------
    always_comb begin
        w_a_src_ok = (!r_a_used[0] || (r_cnt[r_a_ra] == '0)) &&
                     (!r_a_used[1] || (r_cnt[r_a_rb] == '0)) &&
                     (!r_a_used[2] || (r_cnt[r_a_rc] == '0));
        w_b_src_ok = (!r_b_used[0] || (r_cnt[r_b_ra] == '0)) &&
                     (!r_b_used[1] || (r_cnt[r_b_rb] == '0)) &&
                     (!r_b_used[2] || (r_cnt[r_b_rc] == '0));
        // A's result is not yet in the scoreboard when both are decided
        // together, so B reading A's destination must wait a cycle.
        w_b_raw_on_a = r_a_wr &&
                       ((r_b_used[0] && (r_b_ra == r_a_rt)) ||
                        (r_b_used[1] && (r_b_rb == r_a_rt)) ||
                        (r_b_used[2] && (r_b_rc == r_a_rt)));
        w_b_waw_on_a = r_a_wr && r_b_wr && (r_b_rt == r_a_rt);
        // A latency of 0 is treated as 1
        w_a_lat_m1 = (r_a_lat == '0) ? '0 : r_a_lat - LAT_W'(1);
        w_b_lat_m1 = (r_b_lat == '0) ? '0 : r_b_lat - LAT_W'(1);
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (i_branch_taken) begin
            w_state_nxt = c_S_IDLE;
        end else if (w_accept) begin
            w_state_nxt = c_S_PAIR;
        end else begin
            case (r_state)
                c_S_PAIR: begin
                    if (w_a_issue && w_b_issue) begin
                        w_state_nxt = c_S_IDLE;
                    end else if (w_a_issue) begin
                        w_state_nxt = c_S_SINGLE;
                    end
                end
                c_S_SINGLE: begin
                    if (w_b_issue) begin
                        w_state_nxt = c_S_IDLE;
                    end
                end
                default: w_state_nxt = c_S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: output logic (issue decisions and handshake)
    // ------------------------------------------------------------------------
    always_comb begin
        w_a_issue = 1'b0;
        w_b_issue = 1'b0;
        if (!i_branch_taken) begin
            case (r_state)
                c_S_PAIR: begin
                    w_a_issue = w_a_src_ok;
                    w_b_issue = w_a_src_ok && (r_b_pipe != r_a_pipe) &&
                                w_b_src_ok && !w_b_raw_on_a && !w_b_waw_on_a;
                end
                c_S_SINGLE: begin
                    w_b_issue = w_b_src_ok;
                end
                default: begin
                    w_a_issue = 1'b0;
                    w_b_issue = 1'b0;
                end
            endcase
        end
        w_drain    = ((r_state == c_S_PAIR) && w_a_issue && w_b_issue) ||
                     ((r_state == c_S_SINGLE) && w_b_issue);
        w_in_ready = !i_branch_taken && ((r_state == c_S_IDLE) || w_drain);
        w_accept   = i_in_valid && w_in_ready;
        w_stall    = !i_branch_taken && (r_state != c_S_IDLE) &&
                     !w_a_issue && !w_b_issue;
    end

    // ------------------------------------------------------------------------
    // Route issued slots onto the even/odd outputs. When both issue they are
    // on different pipes, so each output has at most one source.
    // ------------------------------------------------------------------------
    always_comb begin
        w_even_issue = 1'b0;
        w_odd_issue  = 1'b0;
        w_even_rt    = '0;
        w_odd_rt     = '0;
        w_even_wr    = 1'b0;
        w_odd_wr     = 1'b0;
        if (w_a_issue) begin
            if (r_a_pipe) begin
                w_odd_issue = 1'b1;
                w_odd_rt    = r_a_rt;
                w_odd_wr    = r_a_wr;
            end else begin
                w_even_issue = 1'b1;
                w_even_rt    = r_a_rt;
                w_even_wr    = r_a_wr;
            end
        end
        if (w_b_issue) begin
            if (r_b_pipe) begin
                w_odd_issue = 1'b1;
                w_odd_rt    = r_b_rt;
                w_odd_wr    = r_b_wr;
            end else begin
                w_even_issue = 1'b1;
                w_even_rt    = r_b_rt;
                w_even_wr    = r_b_wr;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Held slot capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_pipe <= 1'b0;
            r_a_rt   <= '0;
            r_a_wr   <= 1'b0;
            r_a_lat  <= '0;
            r_a_ra   <= '0;
            r_a_rb   <= '0;
            r_a_rc   <= '0;
            r_a_used <= '0;
            r_b_pipe <= 1'b0;
            r_b_rt   <= '0;
            r_b_wr   <= 1'b0;
            r_b_lat  <= '0;
            r_b_ra   <= '0;
            r_b_rb   <= '0;
            r_b_rc   <= '0;
            r_b_used <= '0;
        end else if (w_accept) begin
            r_a_pipe <= i_a_pipe;
            r_a_rt   <= i_a_rt_addr;
            r_a_wr   <= i_a_reg_write;
            r_a_lat  <= i_a_lat;
            r_a_ra   <= i_a_ra;
            r_a_rb   <= i_a_rb;
            r_a_rc   <= i_a_rc;
            r_a_used <= i_a_src_used;
            r_b_pipe <= i_b_pipe;
            r_b_rt   <= i_b_rt_addr;
            r_b_wr   <= i_b_reg_write;
            r_b_lat  <= i_b_lat;
            r_b_ra   <= i_b_ra;
            r_b_rb   <= i_b_rb;
            r_b_rc   <= i_b_rc;
            r_b_used <= i_b_src_used;
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard. A new writer never lowers an outstanding count, so an
    // older long-latency write to the same register still gates readers.
    // ------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_cnt_nxt[i] = (r_cnt[i] == '0) ? '0 : r_cnt[i] - LAT_W'(1);
            if (w_a_issue && r_a_wr && (r_a_rt == c_ADDR_W'(i)) &&
                (w_a_lat_m1 > w_cnt_nxt[i])) begin
                w_cnt_nxt[i] = w_a_lat_m1;
            end
            if (w_b_issue && r_b_wr && (r_b_rt == c_ADDR_W'(i)) &&
                (w_b_lat_m1 > w_cnt_nxt[i])) begin
                w_cnt_nxt[i] = w_b_lat_m1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Issue strobes and stall counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issue_even    <= 1'b0;
            r_issue_odd     <= 1'b0;
            r_issue_even_rt <= '0;
            r_issue_odd_rt  <= '0;
            r_issue_even_wr <= 1'b0;
            r_issue_odd_wr  <= 1'b0;
            r_first_odd     <= 1'b0;
            r_stall_count   <= '0;
        end else begin
            r_issue_even    <= w_even_issue;
            r_issue_odd     <= w_odd_issue;
            r_issue_even_rt <= w_even_rt;
            r_issue_odd_rt  <= w_odd_rt;
            r_issue_even_wr <= w_even_wr;
            r_issue_odd_wr  <= w_odd_wr;
            r_first_odd     <= w_a_issue && w_b_issue && r_a_pipe;
            if (w_stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign o_in_ready             = w_in_ready;
    assign o_issue_even           = r_issue_even;
    assign o_issue_odd            = r_issue_odd;
    assign o_issue_even_rt_addr   = r_issue_even_rt;
    assign o_issue_odd_rt_addr    = r_issue_odd_rt;
    assign o_issue_even_reg_write = r_issue_even_wr;
    assign o_issue_odd_reg_write  = r_issue_odd_wr;
    assign o_first_odd            = r_first_odd;
    assign o_stall_count          = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_issue_scheduler
// Description : Self-checking bench for dual_issue_scheduler. Directed
//               scenarios followed by randomized traffic, all compared
//               against a cycle-level reference model that tracks, per
//               register, the absolute cycle at which its value is ready.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dual_issue_scheduler;

    typedef struct packed {
        logic       pipe;
        logic [6:0] rt;
        logic       wr;
        logic [2:0] lat;
        logic [6:0] ra;
        logic [6:0] rb;
        logic [6:0] rc;
        logic [2:0] used;
    } ins_t;

    logic       clk;
    logic       reset;
    logic       r_valid;
    logic       r_branch;
    ins_t       r_ia;
    ins_t       r_ib;

    logic       w_in_ready;
    logic       w_issue_even;
    logic       w_issue_odd;
    logic [6:0] w_even_rt;
    logic [6:0] w_odd_rt;
    logic       w_even_wr;
    logic       w_odd_wr;
    logic       w_first_odd;
    logic [15:0] w_stall;

    int n_total = 0;
    int n_bad   = 0;

    dual_issue_scheduler #(
        .NUM_REGS (128),
        .LAT_W    (3)
    ) u_dut (
        .clk                    (clk),
        .reset                  (reset),
        .i_in_valid             (r_valid),
        .o_in_ready             (w_in_ready),
        .i_a_pipe               (r_ia.pipe),
        .i_b_pipe               (r_ib.pipe),
        .i_a_rt_addr            (r_ia.rt),
        .i_b_rt_addr            (r_ib.rt),
        .i_a_reg_write          (r_ia.wr),
        .i_b_reg_write          (r_ib.wr),
        .i_a_lat                (r_ia.lat),
        .i_b_lat                (r_ib.lat),
        .i_a_ra                 (r_ia.ra),
        .i_a_rb                 (r_ia.rb),
        .i_a_rc                 (r_ia.rc),
        .i_b_ra                 (r_ib.ra),
        .i_b_rb                 (r_ib.rb),
        .i_b_rc                 (r_ib.rc),
        .i_a_src_used           (r_ia.used),
        .i_b_src_used           (r_ib.used),
        .i_branch_taken         (r_branch),
        .o_issue_even           (w_issue_even),
        .o_issue_odd            (w_issue_odd),
        .o_issue_even_rt_addr   (w_even_rt),
        .o_issue_odd_rt_addr    (w_odd_rt),
        .o_issue_even_reg_write (w_even_wr),
        .o_issue_odd_reg_write  (w_odd_wr),
        .o_first_odd            (w_first_odd),
        .o_stall_count          (w_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: buffer contents plus absolute ready cycle per register
    // ------------------------------------------------------------------------
    int     m_state;        // 0 empty, 1 pair held, 2 only B held
    ins_t   m_a;
    ins_t   m_b;
    longint m_ready_at [128];
    longint m_cyc;
    int     m_stall;
    bit     m_aiss, m_biss, m_in_ready;
    logic [18:0] m_exp_out;  // {even, odd, even_rt, odd_rt, even_wr, odd_wr, first_odd}

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit srcs_ready(input ins_t x);
        bit ok = 1'b1;
        if (x.used[0] && m_ready_at[x.ra] > m_cyc) ok = 1'b0;
        if (x.used[1] && m_ready_at[x.rb] > m_cyc) ok = 1'b0;
        if (x.used[2] && m_ready_at[x.rc] > m_cyc) ok = 1'b0;
        return ok;
    endfunction

    function automatic bit reads_reg(input ins_t x, input logic [6:0] r);
        return (x.used[0] && x.ra == r) || (x.used[1] && x.rb == r) ||
               (x.used[2] && x.rc == r);
    endfunction

    task automatic model_reset();
        m_state = 0;
        for (int i = 0; i < 128; i++) m_ready_at[i] = 0;
        m_stall   = 0;
        m_exp_out = '0;
    endtask

    // Decision for the current cycle, given the inputs now applied.
    task automatic model_decide();
        m_aiss = 1'b0;
        m_biss = 1'b0;
        if (!r_branch) begin
            if (m_state == 1) begin
                m_aiss = srcs_ready(m_a);
                m_biss = m_aiss && (m_a.pipe != m_b.pipe) && srcs_ready(m_b) &&
                         !(m_a.wr && reads_reg(m_b, m_a.rt)) &&
                         !(m_a.wr && m_b.wr && m_a.rt == m_b.rt);
            end else if (m_state == 2) begin
                m_biss = srcs_ready(m_b);
            end
        end
        m_in_ready = !r_branch &&
                     (m_state == 0 || (m_state == 1 && m_aiss && m_biss) ||
                      (m_state == 2 && m_biss));
    endtask

    // Effects of the clock edge that ends the current cycle.
    task automatic model_edge();
        logic       ev, od, ewr, owr;
        logic [6:0] ert, ort;
        int         l;
        ev = 0; od = 0; ewr = 0; owr = 0; ert = 0; ort = 0;
        if (m_aiss) begin
            if (m_a.pipe) begin od = 1; ort = m_a.rt; owr = m_a.wr; end
            else          begin ev = 1; ert = m_a.rt; ewr = m_a.wr; end
            if (m_a.wr) begin
                l = (m_a.lat == 0) ? 1 : int'(m_a.lat);
                if (m_cyc + l > m_ready_at[m_a.rt]) m_ready_at[m_a.rt] = m_cyc + l;
            end
        end
        if (m_biss) begin
            if (m_b.pipe) begin od = 1; ort = m_b.rt; owr = m_b.wr; end
            else          begin ev = 1; ert = m_b.rt; ewr = m_b.wr; end
            if (m_b.wr) begin
                l = (m_b.lat == 0) ? 1 : int'(m_b.lat);
                if (m_cyc + l > m_ready_at[m_b.rt]) m_ready_at[m_b.rt] = m_cyc + l;
            end
        end
        m_exp_out = {ev, od, ert, ort, ewr, owr, (m_aiss && m_biss && m_a.pipe)};
        if (!r_branch && m_state != 0 && !m_aiss && !m_biss && m_stall < 65535)
            m_stall++;
        if (r_branch)                    m_state = 0;
        else if (r_valid && m_in_ready) begin
            m_state = 1; m_a = r_ia; m_b = r_ib;
        end else if (m_state == 1 && m_aiss) m_state = m_biss ? 0 : 2;
        else if (m_state == 2 && m_biss)     m_state = 0;
        m_cyc++;
    endtask

    // One clock cycle: inputs are set by the caller just after a rising edge.
    task automatic run_cycle();
        @(negedge clk);
        model_decide();
        check("in_ready", w_in_ready, m_in_ready);
        @(posedge clk);
        model_edge();
        #1;
        check("issue_out", {w_issue_even, w_issue_odd, w_even_rt, w_odd_rt,
                            w_even_wr, w_odd_wr, w_first_odd}, m_exp_out);
        check("stall_count", w_stall, m_stall);
    endtask

    task automatic drive(input bit v, input bit br, input ins_t a, input ins_t b);
        r_valid  = v;
        r_branch = br;
        r_ia     = a;
        r_ib     = b;
        run_cycle();
    endtask

    function automatic ins_t mk(input bit pipe, input int rt, input bit wr, input int lat,
                                input int ra, input int rb, input int rc, input int used);
        ins_t x;
        x.pipe = pipe;       x.rt = 7'(rt);  x.wr = wr;      x.lat = 3'(lat);
        x.ra = 7'(ra);       x.rb = 7'(rb);  x.rc = 7'(rc);  x.used = 3'(used);
        return x;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t x;
        x.pipe = 1'($urandom_range(0, 1));
        x.rt   = 7'($urandom_range(0, 7));
        x.wr   = 1'($urandom_range(0, 1));
        x.lat  = 3'($urandom_range(0, 7));
        x.ra   = 7'($urandom_range(0, 7));
        x.rb   = 7'($urandom_range(0, 7));
        x.rc   = 7'($urandom_range(0, 7));
        x.used = 3'($urandom_range(0, 7));
        return x;
    endfunction

    ins_t nop_e, nop_o;
    int   s0;

    initial begin
        nop_e = mk(0, 0, 0, 1, 0, 0, 0, 0);
        nop_o = mk(1, 0, 0, 1, 0, 0, 0, 0);
        m_cyc = 0;
        model_reset();
        reset = 1'b1; r_valid = 1'b0; r_branch = 1'b0; r_ia = nop_e; r_ib = nop_o;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset_in_ready", w_in_ready, 1'b1);
        check("reset_outputs", {w_issue_even, w_issue_odd, w_even_rt, w_odd_rt,
                                w_even_wr, w_odd_wr, w_first_odd}, 19'd0);
        check("reset_stall", w_stall, 16'd0);

        // Independent pair: both issue on the first edge after acceptance
        drive(1, 0, mk(0, 5, 1, 2, 0, 0, 0, 0), mk(1, 6, 1, 1, 1, 2, 0, 3));
        drive(0, 0, nop_e, nop_o);
        check("indep_pair", {w_issue_even, w_issue_odd, w_first_odd, w_even_rt, w_odd_rt},
              {1'b1, 1'b1, 1'b0, 7'd5, 7'd6});
        drive(0, 0, nop_e, nop_o);

        // Same pipe: split over two consecutive cycles, no stall
        s0 = int'(w_stall);
        drive(1, 0, mk(0, 11, 1, 1, 0, 0, 0, 0), mk(0, 12, 1, 1, 0, 0, 0, 0));
        drive(0, 0, nop_e, nop_o);
        check("same_pipe_a", {w_issue_even, w_even_rt}, {1'b1, 7'd11});
        drive(0, 0, nop_e, nop_o);
        check("same_pipe_b", {w_issue_even, w_even_rt}, {1'b1, 7'd12});
        drive(0, 0, nop_e, nop_o);
        check("same_pipe_stall", int'(w_stall) - s0, 0);

        // Intra-pair RAW with latency 6: five stalled cycles
        s0 = int'(w_stall);
        drive(1, 0, mk(0, 10, 1, 6, 0, 0, 0, 0), mk(1, 13, 1, 1, 10, 0, 0, 1));
        repeat (9) drive(0, 0, nop_e, nop_o);
        check("intra_raw_stall", int'(w_stall) - s0, 5);

        // Cross-pair RAW with latency 1: back-to-back, no stall
        s0 = int'(w_stall);
        drive(1, 0, mk(0, 3, 1, 1, 0, 0, 0, 0), mk(1, 14, 0, 1, 0, 0, 0, 0));
        drive(1, 0, mk(0, 15, 1, 1, 3, 0, 0, 1), mk(1, 16, 0, 1, 3, 0, 0, 1));
        drive(0, 0, nop_e, nop_o);
        check("cross_raw_issue", {w_issue_even, w_issue_odd, w_even_rt}, {1'b1, 1'b1, 7'd15});
        drive(0, 0, nop_e, nop_o);
        check("cross_raw_stall", int'(w_stall) - s0, 0);

        // Flush while a pair is stalled on r7, then a reader of r7
        drive(1, 0, mk(0, 7, 1, 5, 0, 0, 0, 0), nop_o);
        drive(1, 0, mk(0, 17, 0, 1, 7, 0, 0, 1), mk(1, 18, 0, 1, 0, 0, 0, 0));
        drive(1, 1, mk(0, 19, 0, 1, 0, 0, 0, 0), nop_o);   // flush beats accept
        check("flush_no_issue", {w_issue_even, w_issue_odd}, 2'b00);
        drive(1, 0, mk(0, 23, 0, 1, 7, 0, 0, 1), nop_o);
        repeat (6) drive(0, 0, nop_e, nop_o);

        // WAW: a short-latency writer does not shorten an older long one
        drive(1, 0, mk(0, 20, 1, 7, 0, 0, 0, 0), nop_o);
        drive(1, 0, mk(0, 20, 1, 2, 0, 0, 0, 0), nop_o);
        drive(1, 0, mk(0, 22, 0, 1, 20, 0, 0, 1), nop_o);
        repeat (8) drive(0, 0, nop_e, nop_o);

        // Randomized traffic with one mid-run asynchronous reset
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                r_valid = 1'b0; r_branch = 1'b0;
                reset = 1'b1;
                #1;
                model_reset();
                check("midrun_reset", {w_issue_even, w_issue_odd, w_first_odd, w_stall}, 19'd0);
                #1;
                reset = 1'b0;
            end
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                  rnd_ins(), rnd_ins());
        end
        repeat (10) drive(0, 0, nop_e, nop_o);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dual_issue_scheduler.md
# dual_issue_scheduler

Issue controller between instruction decode and the even/odd execution pipes of the SPU. It holds one decoded instruction pair, tracks outstanding destination registers in a per-register latency scoreboard, and issues each instruction to its pipe once its sources are ready. When a pair cannot go together it splits it, preserving program order, and it flushes on a taken branch.

## Interface
- NUM_REGS, 128: architectural registers tracked by the scoreboard.
- LAT_W, 3: width of per-instruction latency and scoreboard counters.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  decode presents a pair (slot A = first in program order, slot B = second).
- in_ready  out  1  pair is accepted on an edge where in_valid & in_ready.
- a_pipe, b_pipe  in  1 each  0 = even pipe, 1 = odd pipe.
- a_rt_addr, b_rt_addr  in  [0:6] each  destination register.
- a_reg_write, b_reg_write  in  1 each  instruction writes rt.
- a_lat, b_lat  in  LAT_W each  cycles until the result is forwardable, 1..7; 0 is treated as 1.
- a_ra, a_rb, a_rc, b_ra, b_rb, b_rc  in  [0:6] each  source registers.
- a_src_used, b_src_used  in  [2:0] each  bit 0 = ra, bit 1 = rb, bit 2 = rc is read.
- branch_taken  in  1  flush request from the odd pipe.
- issue_even, issue_odd  out  1 each  registered one-cycle issue strobes.
- issue_even_rt_addr, issue_odd_rt_addr  out  [0:6] each  destination of the issued instruction.
- issue_even_reg_write, issue_odd_reg_write  out  1 each  reg_write of the issued instruction.
- first_odd  out  1  the issued odd instruction precedes the issued even one (slot A odd, slot B even).
- stall_count  out  16  saturating count of cycles in which a held instruction did not issue.

## Operation
- Buffer states:
  - IDLE: empty.
  - PAIR: A and B held.
  - SINGLE: only B held.
- Scoreboard: per register, an LAT_W-bit counter cnt.
  - A register is ready when cnt == 0.
  - Every edge, each nonzero cnt decrements by 1.
  - On the edge after an issue decision with reg_write = 1: cnt[rt] <= max(cnt[rt] − 1, lat − 1). This keeps WAW ordering.
- Issue decision for A (PAIR state): issue A if all used sources of A are ready.
- Issue decision for B:
  - In PAIR, B issues in the same cycle only if all of:
    - A issues;
    - b_pipe ≠ a_pipe;
    - all used sources of B are ready;
    - if A writes, no used source of B equals a_rt_addr;
    - if A and B both write, b_rt_addr ≠ a_rt_addr.
  - In SINGLE, B issues when its sources are ready.
- Pipe conflict: when A and B target the same pipe, B always waits for the following cycle.
- State transitions:
  - PAIR with both issuing → IDLE.
  - PAIR with only A issuing → SINGLE.
  - PAIR with A stalled → stays PAIR.
  - SINGLE with B issuing → IDLE.
  - SINGLE with B stalled → stays SINGLE.
- in_ready = (state == IDLE) | (the buffer fully drains this cycle), and low whenever branch_taken = 1. An accepted pair enters PAIR.
- Flush: when branch_taken = 1, no issue decision is made that cycle, the buffer goes to IDLE, and no new pair is accepted.
  - The scoreboard keeps counting for instructions already issued.
  - An instruction issued in the same cycle is not recalled.
- stall_count increments in each PAIR or SINGLE cycle with no issue and no flush. It saturates at 0xFFFF.
- Issue outputs follow the pipe that was issued: the even outputs come from whichever slot is even-pipe, the odd outputs from the odd slot.

## Timing
- Reset values:
  - state = IDLE; all cnt = 0; stall_count = 0.
  - all issue_* = 0; first_odd = 0.
  - in_ready = 1 once reset is deasserted.
- Latency:
  - Pair accepted at edge E can issue at edge E+1, with strobes visible after E+1.
  - Best case is one pair per cycle, with no bubble between consecutive independent pairs.
- Dependence: a writer decided in cycle t with latency L lets its dependent be decided in cycle t+L. L = 1 allows back-to-back issue.
- Strobes are high for exactly one cycle per issued instruction and are never asserted twice for the same slot.
- Simultaneous events:
  - flush and accept in the same cycle: the flush wins and in_ready is low.
  - a scoreboard load and a decrement on the same register: the load expression already accounts for the decrement.
- Reset asserted mid-operation: the buffer is dropped, the scoreboard is zeroed and the outputs clear asynchronously.

## Test plan
- Independent pair: A even, rt = 5, lat = 2; B odd, rt = 6, sources 1, 2. Both issue on the first edge; first_odd = 0; in_ready stays 1.
- Same pipe: A and B both even → issue_even for A, then issue_even for B one cycle later; state goes PAIR → SINGLE → IDLE; stall_count = 0.
- Intra-pair RAW: A writes r10 with lat = 6; B (odd) reads r10. A issues; B issues exactly 6 cycles after A's decision; stall_count = 5.
- Cross-pair RAW: a writer of r3 with lat = 1, then the next pair reads r3 → issues back-to-back with no stall.
- Flush: pair held stalled on r7 (cnt = 4) with branch_taken = 1 → no strobes, state goes to IDLE, cnt[7] continues 3, 2, 1, 0.
- WAW: r20 loaded with cnt = 6, then a new writer to r20 with lat = 2 → cnt keeps counting from the larger value (5, 4, …) and is not reduced to 1.
